// File: rtl/axi_multiport_arbiter.sv
// Arbitrates NUM_PORTS cache-side burst request ports onto one AXI3 master, one transaction at a time.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin grant; the default build uses fixed lowest-index priority.
module axi_multiport_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    // cache side; the data ports carry a port_ prefix so the AXI names stay standard
    input  logic [NUM_PORTS-1:0]       req,
    input  logic [NUM_PORTS-1:0]       wr,
    input  logic [2*NUM_PORTS-1:0]     size,
    input  logic [32*NUM_PORTS-1:0]    addr,
    input  logic [LEN_W*NUM_PORTS-1:0] len,
    input  logic [32*NUM_PORTS-1:0]    port_wdata,
    input  logic [4*NUM_PORTS-1:0]     port_wstrb,
    output logic [NUM_PORTS-1:0]       addr_ok,
    output logic [NUM_PORTS-1:0]       wnext,
    output logic [NUM_PORTS-1:0]       data_ok,
    output logic [31:0]                port_rdata,
    output logic                       last,
    output logic                       resp_err,
    // AXI3 read address
    output logic [ID_W-1:0]            arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [1:0]                 arlock,
    output logic [3:0]                 arcache,
    output logic [2:0]                 arprot,
    output logic                       arvalid,
    input  logic                       arready,
    // AXI3 read data
    input  logic [ID_W-1:0]            rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    // AXI3 write address
    output logic [ID_W-1:0]            awid,
    output logic [31:0]                awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic [1:0]                 awlock,
    output logic [3:0]                 awcache,
    output logic [2:0]                 awprot,
    output logic                       awvalid,
    input  logic                       awready,
    // AXI3 write data
    output logic [ID_W-1:0]            wid,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    // AXI3 write response
    input  logic [ID_W-1:0]            bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] AR   = 3'd1;
    localparam logic [2:0] R    = 3'd2;
    localparam logic [2:0] AW   = 3'd3;
    localparam logic [2:0] W    = 3'd4;
    localparam logic [2:0] B    = 3'd5;

    logic [2:0]           state;
    logic [LEN_W-1:0]     cnt;
    logic [31:0]          g_addr;
    logic [1:0]           g_size;
    logic [LEN_W-1:0]     g_len;
    logic                 g_wr;
    logic [ID_W-1:0]      g_id;
    logic [NUM_PORTS-1:0] g_onehot;

    logic                 grant_valid;
    logic [ID_W-1:0]      grant_idx;
    logic [31:0]          sel_addr;
    logic [1:0]           sel_size;
    logic [LEN_W-1:0]     sel_len;
    logic                 sel_wr;

    // Only one transaction is ever outstanding, so response IDs carry no information.
    logic unused_ids;
    assign unused_ids = ^{rid, bid};

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;

    always_comb begin
        // NOTE: every combinational output is given a default first, so no path holds a stale value (no latch).
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!grant_valid && req[i] && ((int'(rr_ptr) + k) % NUM_PORTS == i)) begin
                    grant_valid = 1'b1;
                    grant_idx   = ID_W'(i);
                end
            end
        end
    end
`else
    always_comb begin
        // NOTE: every combinational output is given a default first, so no path holds a stale value (no latch).
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!grant_valid && req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_addr = '0;
        sel_size = '0;
        sel_len  = '0;
        sel_wr   = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_addr = addr[i*32 +: 32];
                sel_size = size[i*2 +: 2];
                sel_len  = len[i*LEN_W +: LEN_W];
                sel_wr   = wr[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every branch sees the pre-edge values.
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            g_addr <= '0;
            g_size <= '0;
            g_len  <= '0;
            g_wr   <= 1'b0;
            g_id   <= '0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            rr_ptr <= ID_W'(NUM_PORTS - 1);
`endif
        end else begin
            case (state)
                IDLE: if (grant_valid) begin
                    g_addr <= sel_addr;
                    g_size <= sel_size;
                    g_len  <= sel_len;
                    g_wr   <= sel_wr;
                    g_id   <= grant_idx;
                    state  <= sel_wr ? AW : AR;
`ifdef AXI_ARB_ROUND_ROBIN_EN
                    rr_ptr <= grant_idx;
`endif
                end
                AR: if (arready) state <= R;
                R:  if (rvalid && rlast) state <= IDLE;
                AW: if (awready) begin
                    cnt   <= '0;
                    state <= W;
                end
                W: if (wready) begin
                    cnt <= cnt + LEN_W'(1);
                    if (wlast) state <= B;
                end
                B: if (bvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) g_onehot[i] = (g_id == ID_W'(i));
    end

    // Write beat is forwarded straight from the granted port; it advances on wnext.
    always_comb begin
        wdata = '0;
        wstrb = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (g_id == ID_W'(i)) begin
                wdata = port_wdata[i*32 +: 32];
                wstrb = port_wstrb[i*4 +: 4];
            end
        end
    end

    assign arid    = g_id;
    assign araddr  = g_addr;
    assign arlen   = 8'(g_len);
    assign arsize  = {1'b0, g_size};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awid    = g_id;
    assign awaddr  = g_addr;
    assign awlen   = 8'(g_len);
    assign awsize  = {1'b0, g_size};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = g_id;
    assign wlast   = (cnt == g_len);

    assign arvalid    = (state == AR);
    assign rready     = (state == R);
    assign awvalid    = (state == AW);
    assign wvalid     = (state == W);
    assign bready     = (state == B);
    assign port_rdata = rdata;

    always_comb begin
        addr_ok  = '0;
        wnext    = '0;
        data_ok  = '0;
        last     = 1'b0;
        resp_err = 1'b0;
        case (state)
            AR: if (arready) addr_ok = g_onehot;
            AW: if (awready) addr_ok = g_onehot;
            W:  if (wready) wnext = g_onehot;
            R: if (rvalid) begin
                data_ok  = g_onehot;
                last     = rlast;
                resp_err = (rresp != 2'b00);
            end
            B: if (bvalid) begin
                data_ok  = g_onehot;
                last     = 1'b1;
                resp_err = (bresp != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_multiport_arbiter.sv
// Directed bench for axi_multiport_arbiter: the bench plays both the cache masters and the AXI slave.
// Contention expectations follow AXI_ARB_ROUND_ROBIN_EN when the design is built with it.
module tb_axi_multiport_arbiter;

    localparam int NP = 2;
    localparam int IW = 4;
    localparam int LW = 4;

    logic          clk;
    logic          rst;
    logic [NP-1:0] req, wr;
    logic [2*NP-1:0]  size;
    logic [32*NP-1:0] addr;
    logic [LW*NP-1:0] len;
    logic [32*NP-1:0] port_wdata;
    logic [4*NP-1:0]  port_wstrb;
    logic [NP-1:0] addr_ok, wnext, data_ok;
    logic [31:0]   port_rdata;
    logic          last, resp_err;

    logic [IW-1:0] arid, rid, awid, wid, bid;
    logic [31:0]   araddr, awaddr, rdata, wdata;
    logic [7:0]    arlen, awlen;
    logic [2:0]    arsize, awsize, arprot, awprot;
    logic [1:0]    arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]    arcache, awcache, wstrb;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks   = 0;
    int failures = 0;

    axi_multiport_arbiter #(.NUM_PORTS(NP), .ID_W(IW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .req(req), .wr(wr), .size(size), .addr(addr), .len(len),
        .port_wdata(port_wdata), .port_wstrb(port_wstrb),
        .addr_ok(addr_ok), .wnext(wnext), .data_ok(data_ok),
        .port_rdata(port_rdata), .last(last), .resp_err(resp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [1:0] s,
                            input logic [31:0] a, input logic [3:0] l);
        req[p]          = r;
        wr[p]           = w;
        size[p*2 +: 2]  = s;
        addr[p*32 +: 32] = a;
        len[p*4 +: 4]   = l;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req = '0; wr = '0; size = '0; addr = '0; len = '0;
        port_wdata = '0; port_wstrb = '0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        step();
        step();
        rst = 1'b0;
    endtask

    // Called in IDLE with the request already presented; abort >= 0 resets on that beat.
    task automatic read_txn(input int p, input logic [31:0] a, input logic [3:0] l,
                            input logic [1:0] s, input logic [31:0] base, input bit gaps,
                            input bit drop, input int abort);
        logic [1:0] oh;
        oh = 2'(1 << p);
        step();
        check("ar_valid", arvalid, 1);
        check("ar_id", arid, p);
        check("ar_addr", araddr, a);
        check("ar_len", arlen, l);
        check("ar_size", arsize, {1'b0, s});
        check("ar_burst", arburst, 2'b01);
        check("ar_attr", {arlock, arcache, arprot}, 0);
        arready = 1'b1;
        #1;
        check("ar_addr_ok", addr_ok, oh);
        step();
        arready = 1'b0;
        if (drop) req[p] = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    #1;
                    check("r_gap_data_ok", data_ok, 0);
                    step();
                end
            end
            rvalid = 1'b1;
            rdata  = base + b;
            rlast  = (b == int'(l));
            rresp  = 2'b00;
            if (b == abort) begin
                rst = 1'b1;
                step();
                rst = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                #1;
                check("rst_rready", rready, 0);
                check("rst_data_ok", data_ok, 0);
                check("rst_idle", {arvalid, awvalid, wvalid, bready, last}, 0);
                return;
            end
            #1;
            check("r_rready", rready, 1);
            check("r_data_ok", data_ok, oh);
            check("r_data", port_rdata, base + b);
            check("r_last", last, (b == int'(l)));
            check("r_err", resp_err, 0);
            step();
            rvalid = 1'b0;
            rlast  = 1'b0;
        end
        #1;
        check("r_back_idle", {rready, arvalid, data_ok}, 0);
    endtask

    task automatic write_txn(input int p, input logic [31:0] a, input logic [3:0] l,
                             input logic [1:0] s, input logic [31:0] base,
                             input logic [1:0] resp, input bit gaps);
        logic [1:0] oh;
        oh = 2'(1 << p);
        step();
        check("aw_valid", awvalid, 1);
        check("aw_id", awid, p);
        check("aw_addr", awaddr, a);
        check("aw_len", awlen, l);
        check("aw_size", awsize, {1'b0, s});
        check("aw_burst", awburst, 2'b01);
        awready = 1'b1;
        #1;
        check("aw_addr_ok", addr_ok, oh);
        step();
        awready = 1'b0;
        req[p]  = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            port_wdata[p*32 +: 32] = base + b;
            port_wstrb[p*4 +: 4]   = 4'hF;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    wready = 1'b0;
                    #1;
                    check("w_gap_wnext", wnext, 0);
                    check("w_gap_valid", wvalid, 1);
                    step();
                end
            end
            wready = 1'b1;
            #1;
            check("w_valid", wvalid, 1);
            check("w_data", wdata, base + b);
            check("w_strb", wstrb, 4'hF);
            check("w_id", wid, p);
            check("w_last", wlast, (b == int'(l)));
            check("w_wnext", wnext, oh);
            step();
            wready = 1'b0;
        end
        #1;
        check("b_bready", bready, 1);
        check("b_no_wvalid", wvalid, 0);
        check("b_wait_data_ok", data_ok, 0);
        bvalid = 1'b1;
        bresp  = resp;
        #1;
        check("b_data_ok", data_ok, oh);
        check("b_last", last, 1);
        check("b_err", resp_err, (resp != 2'b00));
        step();
        bvalid = 1'b0;
        bresp  = 2'b00;
        #1;
        check("b_back_idle", {bready, data_ok}, 0);
    endtask

    initial begin
        int exp_port;
        rid = '0;
        bid = '0;
        reset_dut();
        #1;
        check("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        check("rst_pulses", {addr_ok, wnext, data_ok, last, resp_err}, 0);

        repeat (3) begin
            step();
            check("no_req_no_grant", {arvalid, awvalid}, 0);
        end

        // single-beat read
        set_port(0, 1'b1, 1'b0, 2'd2, 32'h1FC0_0000, 4'd0);
        read_txn(0, 32'h1FC0_0000, 4'd0, 2'd2, 32'hDEAD_BEEF, 1'b0, 1'b1, -1);

        // 8-beat refill with rvalid gaps
        set_port(1, 1'b1, 1'b0, 2'd2, 32'h0000_1000, 4'd7);
        read_txn(1, 32'h0000_1000, 4'd7, 2'd2, 32'h100, 1'b1, 1'b1, -1);

        // 4-beat writeback with wready gaps
        set_port(0, 1'b1, 1'b1, 2'd2, 32'h0000_2000, 4'd3);
        write_txn(0, 32'h0000_2000, 4'd3, 2'd2, 32'hA0, 2'b00, 1'b1);

        // SLVERR write response, then a normal read
        set_port(1, 1'b1, 1'b1, 2'd1, 32'h0000_3000, 4'd1);
        write_txn(1, 32'h0000_3000, 4'd1, 2'd1, 32'hB0, 2'b10, 1'b0);
        set_port(0, 1'b1, 1'b0, 2'd0, 32'h0000_4000, 4'd0);
        read_txn(0, 32'h0000_4000, 4'd0, 2'd0, 32'h55, 1'b0, 1'b1, -1);

        // contention from a fresh reset
        reset_dut();
        set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_0100, 4'd0);
        set_port(1, 1'b1, 1'b0, 2'd2, 32'h0000_0200, 4'd0);
        for (int t = 0; t < 4; t++) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
            exp_port = t % 2;
`else
            exp_port = 0;
`endif
            read_txn(exp_port, (exp_port == 1) ? 32'h200 : 32'h100, 4'd0, 2'd2,
                     32'h7000 + t, 1'b0, 1'b0, -1);
        end
        req = '0;

        // reset during the 3rd of 8 beats, then a fresh 2-beat read
        set_port(1, 1'b1, 1'b0, 2'd2, 32'h0000_8000, 4'd7);
        read_txn(1, 32'h0000_8000, 4'd7, 2'd2, 32'h300, 1'b0, 1'b1, 2);
        set_port(0, 1'b1, 1'b0, 2'd2, 32'h0000_9000, 4'd1);
        read_txn(0, 32'h0000_9000, 4'd1, 2'd2, 32'h400, 1'b0, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
